// File: rtl/scarv_soc_periph_arb_pkg.sv
// Shared types for the peripheral-port arbiter: requester IDs and request payloads.
package scarv_soc_periph_arb_pkg;

   localparam int NREQ   = 2;
   localparam int ID_W   = 1;
   localparam int PKT_AW = 32;
   localparam int PKT_DW = 32;

   typedef logic [ID_W-1:0] req_id_t;

   typedef struct packed {
      logic                  wen;
      logic [PKT_DW/8-1:0]   strb;
      logic [PKT_AW-1:0]     addr;
      logic [PKT_DW-1:0]     wdata;
   } req_pkt_t;

   function automatic req_id_t other_id(input req_id_t id);
      return ~id;
   endfunction

endpackage

// File: rtl/scarv_soc_periph_arb_idfifo.sv
// Owner-ID FIFO: remembers which requester issued each outstanding transaction.
module scarv_soc_periph_arb_idfifo
   import scarv_soc_periph_arb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     push_i,
   input  req_id_t                  id_i,
   input  logic                     pop_i,
   output req_id_t                  head_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);

   req_id_t         mem_q [DEPTH];
   logic [PW-1:0]   wrPtr_q, wrPtr_d;
   logic [PW-1:0]   rdPtr_q, rdPtr_d;
   logic [PW:0]     count_q, count_d;
   logic            doPush;
   logic            doPop;

   assign full_o  = (count_q == (PW+1)'(DEPTH));
   assign empty_o = (count_q == '0);
   assign count_o = count_q;
   assign head_o  = mem_q[rdPtr_q];

   assign doPush = push_i && !full_o;
   assign doPop  = pop_i && !empty_o;

   always_comb begin
      wrPtr_d = wrPtr_q;
      rdPtr_d = rdPtr_q;
      count_d = count_q;
      if (doPush) wrPtr_d = wrPtr_q + 1'b1;
      if (doPop)  rdPtr_d = rdPtr_q + 1'b1;
      case ({doPush, doPop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wrPtr_q <= '0;
         rdPtr_q <= '0;
         count_q <= '0;
      end else begin
         wrPtr_q <= wrPtr_d;
         rdPtr_q <= rdPtr_d;
         count_q <= count_d;
      end
   end

   // Storage needs no reset: the count and pointers decide what is valid.
   always_ff @(posedge clk_i) begin
      if (doPush) mem_q[wrPtr_q] <= id_i;
   end

endmodule

// File: rtl/scarv_soc_periph_arbiter.sv
// Round-robin arbiter for the peripheral memory port; routes in-order responses
// back to whichever requester issued the matching request.
module scarv_soc_periph_arbiter
   import scarv_soc_periph_arb_pkg::*;
#(
   parameter int AW              = 32,
   parameter int DW              = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic            g_clk,
   input  logic            g_reset,

   input  logic            r0_req,
   output logic            r0_gnt,
   input  logic            r0_wen,
   input  logic [DW/8-1:0] r0_strb,
   input  logic [AW-1:0]   r0_addr,
   input  logic [DW-1:0]   r0_wdata,
   output logic            r0_recv,
   input  logic            r0_ack,
   output logic [DW-1:0]   r0_rdata,
   output logic            r0_error,

   input  logic            r1_req,
   output logic            r1_gnt,
   input  logic            r1_wen,
   input  logic [DW/8-1:0] r1_strb,
   input  logic [AW-1:0]   r1_addr,
   input  logic [DW-1:0]   r1_wdata,
   output logic            r1_recv,
   input  logic            r1_ack,
   output logic [DW-1:0]   r1_rdata,
   output logic            r1_error,

   output logic            d_req,
   output logic            d_wen,
   output logic [DW/8-1:0] d_strb,
   output logic [AW-1:0]   d_addr,
   output logic [DW-1:0]   d_wdata,
   input  logic            d_gnt,
   input  logic            d_recv,
   input  logic [DW-1:0]   d_rdata,
   input  logic            d_error,
   output logic            d_ack,

   output logic            spurious_rsp
);

   localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

   typedef struct packed {
      logic            wen;
      logic [DW/8-1:0] strb;
      logic [AW-1:0]   addr;
      logic [DW-1:0]   wdata;
   } pkt_t;

   pkt_t             pkt [NREQ];
   pkt_t             selPkt;
   logic [NREQ-1:0]  reqVec;
   logic [NREQ-1:0]  ackVec;

   logic     lock_q, lock_d;
   req_id_t  lockSel_q, lockSel_d;
   req_id_t  lastGrant_q, lastGrant_d;
   logic     spurious_q, spurious_d;

   req_id_t          sel;
   logic             selReq;
   logic             xfer;
   logic             respVld;
   logic             pop;
   req_id_t          head;
   logic             full;
   logic             empty;
   logic [CW-1:0]    outstanding;

   assign reqVec = {r1_req, r0_req};
   assign ackVec = {r1_ack, r0_ack};
   assign pkt[0] = '{wen: r0_wen, strb: r0_strb, addr: r0_addr, wdata: r0_wdata};
   assign pkt[1] = '{wen: r1_wen, strb: r1_strb, addr: r1_addr, wdata: r1_wdata};

   // A requester presented but not yet accepted keeps the port until the device takes it.
   always_comb begin
      sel    = lockSel_q;
      selReq = 1'b0;
      if (lock_q) begin
         selReq = reqVec[lockSel_q];
      end else begin
         case (reqVec)
            2'b01:   begin sel = 1'b0;                   selReq = 1'b1; end
            2'b10:   begin sel = 1'b1;                   selReq = 1'b1; end
            2'b11:   begin sel = other_id(lastGrant_q);  selReq = 1'b1; end
            default: begin sel = lockSel_q;              selReq = 1'b0; end
         endcase
      end
   end

   assign d_req  = !g_reset && selReq && !full;
   assign xfer   = d_req && d_gnt;
   assign r0_gnt = xfer && (sel == 1'b0);
   assign r1_gnt = xfer && (sel == 1'b1);

   assign selPkt  = d_req ? pkt[sel] : '0;
   assign d_wen   = selPkt.wen;
   assign d_strb  = selPkt.strb;
   assign d_addr  = selPkt.addr;
   assign d_wdata = selPkt.wdata;

   assign respVld  = !g_reset && d_recv && !empty;
   assign r0_recv  = respVld && (head == 1'b0);
   assign r1_recv  = respVld && (head == 1'b1);
   assign r0_rdata = r0_recv ? d_rdata : '0;
   assign r1_rdata = r1_recv ? d_rdata : '0;
   assign r0_error = r0_recv && d_error;
   assign r1_error = r1_recv && d_error;

   // With nothing outstanding a stray response is drained rather than stalling the device.
   assign d_ack = !g_reset && (empty ? d_recv : ackVec[head]);
   assign pop   = respVld && d_ack;

   assign spurious_rsp = spurious_q;

   always_comb begin
      lock_d      = lock_q;
      lockSel_d   = lockSel_q;
      lastGrant_d = lastGrant_q;
      spurious_d  = spurious_q || (d_recv && empty);
      if (xfer) begin
         lock_d      = 1'b0;
         lastGrant_d = sel;
      end else if (d_req) begin
         lock_d    = 1'b1;
         lockSel_d = sel;
      end
   end

   always_ff @(posedge g_clk or posedge g_reset) begin
      if (g_reset) begin
         lock_q      <= 1'b0;
         lockSel_q   <= 1'b0;
         lastGrant_q <= 1'b1;
         spurious_q  <= 1'b0;
      end else begin
         lock_q      <= lock_d;
         lockSel_q   <= lockSel_d;
         lastGrant_q <= lastGrant_d;
         spurious_q  <= spurious_d;
      end
   end

   scarv_soc_periph_arb_idfifo #(
      .DEPTH   (MAX_OUTSTANDING)
   ) u_idfifo (
      .clk_i   (g_clk),
      .rst_i   (g_reset),
      .push_i  (xfer),
      .id_i    (sel),
      .pop_i   (pop),
      .head_o  (head),
      .full_o  (full),
      .empty_o (empty),
      .count_o (outstanding)
   );

   assert property (@(posedge g_clk) disable iff (g_reset) outstanding <= CW'(MAX_OUTSTANDING));

endmodule

// File: tb/tb_scarv_soc_periph_arbiter.sv
// Self-checking bench for the peripheral arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_scarv_soc_periph_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int DEPTH = 4;

   logic            clk = 1'b0;
   logic            rst;
   logic [1:0]      req, wen, ack, gnt, recv, err;
   logic [DW/8-1:0] strb  [2];
   logic [AW-1:0]   addr  [2];
   logic [DW-1:0]   wdata [2];
   logic [DW-1:0]   rdata [2];
   logic            dReq, dWen, dGnt, dRecv, dError, dAck, spurious;
   logic [DW/8-1:0] dStrb;
   logic [AW-1:0]   dAddr;
   logic [DW-1:0]   dWdata, dRdata;

   int total;
   int bad;

   always #5 clk = ~clk;

   scarv_soc_periph_arbiter #(.AW(AW), .DW(DW), .MAX_OUTSTANDING(DEPTH)) dut (
      .g_clk(clk), .g_reset(rst),
      .r0_req(req[0]), .r0_gnt(gnt[0]), .r0_wen(wen[0]), .r0_strb(strb[0]),
      .r0_addr(addr[0]), .r0_wdata(wdata[0]), .r0_recv(recv[0]), .r0_ack(ack[0]),
      .r0_rdata(rdata[0]), .r0_error(err[0]),
      .r1_req(req[1]), .r1_gnt(gnt[1]), .r1_wen(wen[1]), .r1_strb(strb[1]),
      .r1_addr(addr[1]), .r1_wdata(wdata[1]), .r1_recv(recv[1]), .r1_ack(ack[1]),
      .r1_rdata(rdata[1]), .r1_error(err[1]),
      .d_req(dReq), .d_wen(dWen), .d_strb(dStrb), .d_addr(dAddr), .d_wdata(dWdata),
      .d_gnt(dGnt), .d_recv(dRecv), .d_rdata(dRdata), .d_error(dError), .d_ack(dAck),
      .spurious_rsp(spurious)
   );

   task automatic clearInputs();
      req = '0; wen = '0; ack = '0;
      for (int n = 0; n < 2; n++) begin
         strb[n] = '0; addr[n] = '0; wdata[n] = '0;
      end
      dGnt = 1'b0; dRecv = 1'b0; dRdata = '0; dError = 1'b0;
   endtask

   // Leaves the caller just after a falling edge with reset released.
   task automatic doReset();
      rst = 1'b1;
      clearInputs();
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clearInputs();
      req = 2'b11; dGnt = 1'b1; dRecv = 1'b1; ack = 2'b11; addr[0] = 32'h1234_5678;
      #1;
      total++; if (dReq !== 1'b0) begin bad++; $display("[TB] FAIL reset_dreq got=%0b exp=0", dReq); end
      total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL reset_gnt got=%b exp=00", gnt); end
      total++; if (recv !== 2'b00) begin bad++; $display("[TB] FAIL reset_recv got=%b exp=00", recv); end
      total++; if (dAck !== 1'b0) begin bad++; $display("[TB] FAIL reset_dack got=%0b exp=0", dAck); end
      total++; if (dAddr !== '0) begin bad++; $display("[TB] FAIL reset_daddr got=%h exp=0", dAddr); end
      total++; if (spurious !== 1'b0) begin bad++; $display("[TB] FAIL reset_spurious got=%0b exp=0", spurious); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL reset_first_gnt got=%b exp=01", gnt); end
      total++; if (recv !== 2'b00) begin bad++; $display("[TB] FAIL reset_empty_recv got=%b exp=00", recv); end
      total++; if (dAck !== 1'b1) begin bad++; $display("[TB] FAIL reset_drain_ack got=%0b exp=1", dAck); end
      @(negedge clk);
      clearInputs();
   endtask

   task automatic test_single_read();
      doReset();
      req[0] = 1'b1; addr[0] = 32'h1000_1000; dGnt = 1'b1;
      #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL single_gnt got=%b exp=01", gnt); end
      total++; if (dAddr !== 32'h1000_1000) begin bad++; $display("[TB] FAIL single_addr got=%h exp=10001000", dAddr); end
      @(negedge clk);
      req[0] = 1'b0; dGnt = 1'b0;
      #1;
      total++; if (gnt !== 2'b00) begin bad++; $display("[TB] FAIL single_gnt_once got=%b exp=00", gnt); end
      @(negedge clk);
      #1;
      total++; if (recv !== 2'b00) begin bad++; $display("[TB] FAIL single_no_early_recv got=%b exp=00", recv); end
      @(negedge clk);
      dRecv = 1'b1; dRdata = 32'hA5A5_0001; ack[0] = 1'b1;
      #1;
      total++; if (recv !== 2'b01) begin bad++; $display("[TB] FAIL single_recv got=%b exp=01", recv); end
      total++; if (rdata[0] !== 32'hA5A5_0001) begin bad++; $display("[TB] FAIL single_rdata got=%h exp=a5a50001", rdata[0]); end
      total++; if (dAck !== 1'b1) begin bad++; $display("[TB] FAIL single_dack got=%0b exp=1", dAck); end
      @(negedge clk);
      clearInputs();
   endtask

   task automatic test_contention();
      doReset();
      req = 2'b11; addr[0] = 32'h0000_0A00; addr[1] = 32'h0000_0B00; dGnt = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         total++;
         if (gnt !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
            bad++; $display("[TB] FAIL contention_gnt%0d got=%b exp=%b", i, gnt, (i % 2 == 0) ? 2'b01 : 2'b10);
         end
         @(negedge clk);
      end
      #1;
      total++; if (dReq !== 1'b0) begin bad++; $display("[TB] FAIL contention_full got=%0b exp=0", dReq); end
      clearInputs();
   endtask

   task automatic test_stall_lock();
      doReset();
      req[1] = 1'b1; addr[1] = 32'h0000_B111; addr[0] = 32'h0000_A000;
      for (int i = 0; i < 3; i++) begin
         #1;
         total++; if (dAddr !== 32'h0000_B111 || gnt !== 2'b00) begin bad++; $display("[TB] FAIL stall_hold%0d addr=%h gnt=%b exp addr=0000b111 gnt=00", i, dAddr, gnt); end
         @(negedge clk);
      end
      req[0] = 1'b1;
      #1;
      total++; if (dAddr !== 32'h0000_B111) begin bad++; $display("[TB] FAIL stall_locked got=%h exp=0000b111", dAddr); end
      @(negedge clk);
      dGnt = 1'b1;
      #1;
      total++; if (gnt !== 2'b10 || dAddr !== 32'h0000_B111) begin bad++; $display("[TB] FAIL stall_release gnt=%b addr=%h exp gnt=10 addr=0000b111", gnt, dAddr); end
      @(negedge clk);
      req[1] = 1'b0;
      #1;
      total++; if (gnt !== 2'b01 || dAddr !== 32'h0000_A000) begin bad++; $display("[TB] FAIL stall_next gnt=%b addr=%h exp gnt=01 addr=0000a000", gnt, dAddr); end
      @(negedge clk);
      clearInputs();
   endtask

   task automatic test_full();
      doReset();
      req[0] = 1'b1; dGnt = 1'b1;
      for (int i = 0; i < DEPTH; i++) begin
         #1;
         total++; if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL full_fill%0d got=%b exp=01", i, gnt); end
         @(negedge clk);
      end
      dRecv = 1'b1; ack[0] = 1'b1; dRdata = 32'h0000_F00D;
      #1;
      total++; if (dReq !== 1'b0) begin bad++; $display("[TB] FAIL full_no_bypass got=%0b exp=0", dReq); end
      total++; if (recv !== 2'b01 || dAck !== 1'b1) begin bad++; $display("[TB] FAIL full_pop recv=%b dack=%0b exp recv=01 dack=1", recv, dAck); end
      @(negedge clk);
      dRecv = 1'b0; ack = '0;
      #1;
      total++; if (dReq !== 1'b1 || gnt !== 2'b01) begin bad++; $display("[TB] FAIL full_resume dreq=%0b gnt=%b exp dreq=1 gnt=01", dReq, gnt); end
      @(negedge clk);
      clearInputs();
   endtask

   task automatic test_interleaved();
      logic [1:0] order [3];
      order[0] = 2'b01; order[1] = 2'b10; order[2] = 2'b01;
      doReset();
      dGnt = 1'b1;
      for (int i = 0; i < 3; i++) begin
         req = order[i];
         #1;
         total++; if (gnt !== order[i]) begin bad++; $display("[TB] FAIL inter_gnt%0d got=%b exp=%b", i, gnt, order[i]); end
         @(negedge clk);
      end
      req = '0; dGnt = 1'b0;
      dRecv = 1'b1; dRdata = 32'h11; ack = 2'b01;
      #1;
      total++; if (recv !== 2'b01 || rdata[0] !== 32'h11 || dAck !== 1'b1) begin bad++; $display("[TB] FAIL inter_rsp0 recv=%b rdata=%h dack=%0b exp recv=01 rdata=11 dack=1", recv, rdata[0], dAck); end
      @(negedge clk);
      dRdata = 32'h22;
      for (int i = 0; i < 2; i++) begin
         #1;
         total++; if (recv !== 2'b10 || rdata[1] !== 32'h22 || dAck !== 1'b0) begin bad++; $display("[TB] FAIL inter_hold%0d recv=%b rdata=%h dack=%0b exp recv=10 rdata=22 dack=0", i, recv, rdata[1], dAck); end
         @(negedge clk);
      end
      ack = 2'b10;
      #1;
      total++; if (recv !== 2'b10 || dAck !== 1'b1) begin bad++; $display("[TB] FAIL inter_rsp1 recv=%b dack=%0b exp recv=10 dack=1", recv, dAck); end
      @(negedge clk);
      dRdata = 32'h33; ack = 2'b01;
      #1;
      total++; if (recv !== 2'b01 || rdata[0] !== 32'h33 || dAck !== 1'b1) begin bad++; $display("[TB] FAIL inter_rsp2 recv=%b rdata=%h dack=%0b exp recv=01 rdata=33 dack=1", recv, rdata[0], dAck); end
      @(negedge clk);
      clearInputs();
   endtask

   task automatic test_spurious_reset();
      doReset();
      dRecv = 1'b1;
      #1;
      total++; if (dAck !== 1'b1 || recv !== 2'b00) begin bad++; $display("[TB] FAIL spur_drain dack=%0b recv=%b exp dack=1 recv=00", dAck, recv); end
      @(negedge clk);
      dRecv = 1'b0;
      repeat (3) @(negedge clk);
      #1;
      total++; if (spurious !== 1'b1) begin bad++; $display("[TB] FAIL spur_sticky got=%0b exp=1", spurious); end
      dGnt = 1'b1; req = 2'b10;
      @(negedge clk);
      req = 2'b01;
      @(negedge clk);
      req = 2'b11; dRecv = 1'b1; ack = 2'b11;
      rst = 1'b1;
      #1;
      total++; if (dReq !== 1'b0 || gnt !== 2'b00 || recv !== 2'b00 || dAck !== 1'b0) begin bad++; $display("[TB] FAIL spur_reset_out dreq=%0b gnt=%b recv=%b dack=%0b exp all 0", dReq, gnt, recv, dAck); end
      total++; if (spurious !== 1'b0) begin bad++; $display("[TB] FAIL spur_reset_clear got=%0b exp=0", spurious); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      total++; if (gnt !== 2'b01) begin bad++; $display("[TB] FAIL spur_first_gnt got=%b exp=01", gnt); end
      total++; if (recv !== 2'b00 || dAck !== 1'b1) begin bad++; $display("[TB] FAIL spur_fifo_empty recv=%b dack=%0b exp recv=00 dack=1", recv, dAck); end
      @(negedge clk);
      clearInputs();
   endtask

   // Reference: outstanding owners are a queue; a requester offered but not yet
   // accepted keeps the port; otherwise the one not served last wins a tie.
   task automatic test_random();
      int         ownerQ [$];
      int         lastG;
      int         offered;
      int         sel;
      int         devPend;
      bit         devHold;
      bit         hold [2];
      logic       expDReq, expDAck;
      logic [1:0] expGnt, expRecv;
      doReset();
      lastG = 1; offered = -1; devPend = 0; devHold = 1'b0;
      hold[0] = 1'b0; hold[1] = 1'b0;
      for (int cyc = 0; cyc < 600; cyc++) begin
         for (int n = 0; n < 2; n++) begin
            if (!hold[n] && $urandom_range(0, 2) == 0) begin
               hold[n] = 1'b1; addr[n] = $urandom; wdata[n] = $urandom;
               wen[n] = 1'($urandom_range(0, 1)); strb[n] = 4'($urandom);
            end
            req[n] = hold[n];
            ack[n] = ($urandom_range(0, 3) != 0);
         end
         if (!devHold && devPend > 0 && $urandom_range(0, 1) == 1) begin
            devHold = 1'b1; dRdata = $urandom; dError = 1'($urandom_range(0, 1));
         end
         dRecv = devHold;
         dGnt  = ($urandom_range(0, 2) != 0);
         #1;
         if (offered >= 0)       sel = offered;
         else if (req == 2'b11)  sel = 1 - lastG;
         else if (req[0])        sel = 0;
         else if (req[1])        sel = 1;
         else                    sel = -1;
         expDReq = (sel >= 0) && (ownerQ.size() < DEPTH);
         expGnt  = '0;
         if (expDReq && dGnt) expGnt[sel] = 1'b1;
         expRecv = '0;
         if (ownerQ.size() > 0 && dRecv) expRecv[ownerQ[0]] = 1'b1;
         expDAck = (ownerQ.size() == 0) ? dRecv : ack[ownerQ[0]];
         total++; if (dReq !== expDReq) begin bad++; $display("[TB] FAIL rnd_dreq cyc=%0d got=%0b exp=%0b", cyc, dReq, expDReq); end
         total++; if (gnt !== expGnt) begin bad++; $display("[TB] FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, expGnt); end
         if (expDReq) begin
            total++;
            if (dAddr !== addr[sel] || dWdata !== wdata[sel] || dWen !== wen[sel] || dStrb !== strb[sel]) begin
               bad++; $display("[TB] FAIL rnd_payload cyc=%0d addr=%h exp=%h wdata=%h exp=%h", cyc, dAddr, addr[sel], dWdata, wdata[sel]);
            end
         end
         total++; if (recv !== expRecv) begin bad++; $display("[TB] FAIL rnd_recv cyc=%0d got=%b exp=%b", cyc, recv, expRecv); end
         if (expRecv != 2'b00) begin
            total++;
            if (rdata[ownerQ[0]] !== dRdata || err[ownerQ[0]] !== dError) begin
               bad++; $display("[TB] FAIL rnd_rdata cyc=%0d got=%h/%0b exp=%h/%0b", cyc, rdata[ownerQ[0]], err[ownerQ[0]], dRdata, dError);
            end
         end
         total++; if (dAck !== expDAck) begin bad++; $display("[TB] FAIL rnd_dack cyc=%0d got=%0b exp=%0b", cyc, dAck, expDAck); end
         @(posedge clk);
         if (ownerQ.size() > 0 && dRecv && expDAck) begin
            void'(ownerQ.pop_front());
            devHold = 1'b0; devPend--;
         end
         if (expDReq && dGnt) begin
            ownerQ.push_back(sel);
            lastG = sel; offered = -1; hold[sel] = 1'b0; devPend++;
         end else if (expDReq) begin
            offered = sel;
         end
         @(negedge clk);
      end
      total++; if (spurious !== 1'b0) begin bad++; $display("[TB] FAIL rnd_no_spurious got=%0b exp=0", spurious); end
      clearInputs();
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      clearInputs();
      test_reset();
      test_single_read();
      test_contention();
      test_stall_lock();
      test_full();
      test_interleaved();
      test_spurious_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/scarv_soc_periph_arbiter.md
Name: scarv_soc_periph_arbiter

Overview:
- Two-requester arbiter in front of the 64KB peripheral subsystem memory port. Requester 0 is the CPU data port; requester 1 is the debug/DMA port.
- Grants the shared request channel round-robin and records which requester owns each outstanding transaction. Routes in-order responses back to the owner.
- Sits between the SoC interconnect and the peripheral router.

Parameters:
- AW, 32, address width.
- DW, 32, data width; strobe width is DW/8.
- MAX_OUTSTANDING, 4, depth of the owner-ID FIFO (power of two, >=2).

Ports:
- g_clk  input  1  single clock.
- g_reset  input  1  asynchronous, active-high reset.
- rN_req  input  1  requester N request valid (N = 0, 1).
- rN_gnt  output  1  requester N request accepted.
- rN_wen  input  1  write enable.
- rN_strb  input  DW/8  byte strobes.
- rN_addr  input  AW  address.
- rN_wdata  input  DW  write data.
- rN_recv  output  1  response valid to requester N.
- rN_ack  input  1  requester N accepts response.
- rN_rdata  output  DW  read data.
- rN_error  output  1  response error.
- d_req, d_wen, d_strb, d_addr, d_wdata  output  1/1/DW8/AW/DW  request to device.
- d_gnt  input  1  device accepts request.
- d_recv, d_rdata, d_error  input  1/DW/1  device response.
- d_ack  output  1  response accepted.
- spurious_rsp  output  1  sticky: response arrived with no transaction outstanding.

Behaviour:
- Reset (async, g_reset=1): FIFO empty, count=0, lock=0, last_grant=1 (requester 0 wins first), spurious_rsp=0. All outputs 0 while in reset.
- Request handshake: a transfer occurs when d_req && d_gnt. A requester must hold req and payload stable until it sees gnt.
- Selection:
  - If lock=1, selection stays at locked_sel.
  - Else if only one requester has req, select it.
  - Else if both have req, select the one that is not last_grant.
  - Else no selection.
- Forwarding: d_req = sel_req && !full; payload is muxed from sel. rN_gnt = (sel==N) && d_req && d_gnt (combinational).
- Lock: set when d_req && !d_gnt; cleared on the transfer. This prevents switching mid-handshake. While full, lock holds and d_req=0.
- On each transfer: push sel into the FIFO, last_grant<=sel, lock<=0.
- Full: count==MAX_OUTSTANDING uses the registered count. Full blocks push even if a pop happens in the same cycle, so there is no bypass. Adds one bubble; accepted.
- Response routing: head = FIFO head ID.
  - r[head]_recv = d_recv && !empty, with rdata/error from the device. The other requester's recv is 0.
  - d_ack = r[head]_ack.
  - Pop on d_recv && d_ack && !empty.
- Simultaneous push and pop when not full: count unchanged, both pointers advance.
- Empty with d_recv=1: d_ack=1 to drain the response, spurious_rsp<=1 (cleared only by reset), no rN_recv asserted.
- Pointer wrap: log2(MAX_OUTSTANDING)-bit pointers wrap naturally. count is log2+1 bits.
- Responses return strictly in request order. Latency is zero added cycles on both request and response paths (combinational muxing; state updates on the clock edge).
- Reset mid-operation discards outstanding IDs. The device must be reset in the same cycle.

Decomposition:
- Package scarv_soc_periph_arb_pkg: typedef req_id_t (1 bit), localparams NREQ=2 and ID_W. Also a struct bundling wen/strb/addr/wdata.
- Sub-module scarv_soc_periph_arb_idfifo holds the parameterised owner-ID FIFO: push, pop, head, full, empty, count, async active-high reset.
- Arbitration and muxing stay in the top module.

Test Plan:
- Single read: r0 reads 0x1000_1000, device gnt in the same cycle, recv 2 cycles later with rdata=0xA5A5_0001 -> r0_gnt for 1 cycle, r0_recv with 0xA5A5_0001, r1_recv stays 0.
- Contention: r0 and r1 both hold req for 4 transfers with d_gnt=1 -> grant order r0, r1, r0, r1.
- Stall lock: r1 requests alone with d_gnt=0 for 3 cycles, then r0 also requests -> d_addr stays r1's until the d_gnt cycle, then r0 is granted next.
- Full: 4 grants with no responses (MAX_OUTSTANDING=4) -> d_req=0 on the 5th. After one response is acked, the next cycle d_req=1.
- Interleaved ownership: grants r0, r1, r0; responses 0x11, 0x22, 0x33 with r1_ack held 0 for 2 cycles -> 0x11 to r0, 0x22 held on r1 until ack, 0x33 to r0. d_ack follows the owner's ack.
- Spurious and reset: d_recv=1 with FIFO empty -> d_ack=1, spurious_rsp=1 stays set. Assert g_reset mid-burst with 2 outstanding -> all outputs 0 immediately, FIFO empty, the first grant after reset goes to r0.
